// File: rtl/fixed_mult_seq.sv
// fixed_mult_seq
// Sequential signed fixed-point multiplier using radix-2 Booth recoding,
// one Booth step per clock. Two Q(ent.frac) operands with sign bit produce
// a full-precision Q(2ent.2frac) product with sign, PW = 2*ent+2*frac+1 bits.
// The product feeds the truncation/saturation stage directly.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request a multiply, sampled only while idle
//   a, b     signed operands, cant_bits wide, Q(ent.frac)
//   busy     high from the cycle after an accepted start until done
//   done     one-cycle pulse, product/ovf valid from this cycle on
//   ovf      exact product did not fit in PW bits (only -min * -min)
//   product  signed product, held until the next operation completes
//
// Optional build macro:
//   FIXED_MULT_FAST_ZERO_EN  when defined, a start with a zero operand skips
//                            the Booth loop and completes one cycle after
//                            acceptance with product 0.

module fixed_mult_seq #(
    parameter  int cant_bits = 25,
    parameter  int ent       = 10,
    parameter  int frac      = 14,
    localparam int PW        = 2*ent + 2*frac + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [cant_bits-1:0] a,
    input  logic [cant_bits-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic [PW-1:0]        product
);

    localparam int AW = 2*cant_bits;
    localparam int CW = $clog2(cant_bits + 1);

    // The only result that cannot be represented in PW bits: (-2^(n-1))^2
    localparam logic [AW-1:0] SAT_VAL = {2'b01, {(AW-2){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state, state_nxt;
    logic signed [AW-1:0]  mcand;
    logic signed [AW-1:0]  acc;
    logic [cant_bits-1:0]  b_reg;
    logic                  q_m1;
    logic [CW-1:0]         count;

    logic signed [AW-1:0]  sum;
    logic [AW+cant_bits:0] shifted;
    logic [AW-1:0]         result;
    logic                  sat;
    logic                  zero_op;

    // Booth step datapath. The accumulator is a full 2*cant_bits wide, so
    // adding or subtracting the sign-extended multiplicand never overflows,
    // even for the most-negative operand pair. The shift drops q(-1) and
    // replicates the accumulator sign into the top.
    always_comb begin
        sum = acc;
        case ({b_reg[0], q_m1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
        shifted = {sum[AW-1], sum, b_reg};
        result  = {acc[cant_bits-1:0], b_reg};
        sat     = (result == SAT_VAL);
        zero_op = (a == '0) || (b == '0);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. CALC leaves when the last step is being taken, so
    // exactly cant_bits steps are performed before DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef FIXED_MULT_FAST_ZERO_EN
                    state_nxt = zero_op ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (count == CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs. Operands are only captured on an
    // accepted start, so a and b are free to change at any other time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc     <= '0;
            b_reg   <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= {{cant_bits{a[cant_bits-1]}}, a};
                        acc   <= '0;
                        b_reg <= b;
                        q_m1  <= 1'b0;
                        count <= CW'(cant_bits);
                        busy  <= 1'b1;
`ifdef FIXED_MULT_FAST_ZERO_EN
                        if (zero_op) begin
                            b_reg <= '0;
                        end
`endif
                    end
                end
                CALC: begin
                    acc   <= shifted[AW+cant_bits:cant_bits+1];
                    b_reg <= shifted[cant_bits:1];
                    q_m1  <= shifted[0];
                    count <= count - CW'(1);
                end
                DONE: begin
                    if (sat) begin
                        product <= {1'b0, {(PW-1){1'b1}}};
                        ovf     <= 1'b1;
                    end else begin
                        product <= result[PW-1:0];
                        ovf     <= 1'b0;
                    end
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_mult_seq.sv
// tb_fixed_mult_seq
// Self-checking bench for fixed_mult_seq. Expected results come from a
// 64-bit integer multiply model pushed to a scoreboard queue at start and
// popped when the done pulse appears.

module tb_fixed_mult_seq;

    localparam int N  = 25;
    localparam int PW = 49;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  a     = '0;
    logic [N-1:0]  b     = '0;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [PW-1:0] product;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [PW-1:0] prod;
        logic          ovf;
        int            lat;
        string         tag;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    fixed_mult_seq #(.cant_bits(N), .ent(10), .frac(14)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .product(product)
    );

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference: exact signed product, saturated only for (-2^24)^2
    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input string tag);
        exp_t   e;
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        if (p == (longint'(1) <<< 48)) begin
            e.prod = {1'b0, {(PW-1){1'b1}}};
            e.ovf  = 1'b1;
        end else begin
            e.prod = p[PW-1:0];
            e.ovf  = 1'b0;
        end
        e.lat = 26;
`ifdef FIXED_MULT_FAST_ZERO_EN
        if (x == '0 || y == '0) e.lat = 1;
`endif
        e.tag = tag;
        return e;
    endfunction

    // Raise start for one edge; returns #1 after the accepting edge
    task automatic driveStart(input logic [N-1:0] x, input logic [N-1:0] y);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y, input string tag);
        sbq.push_back(model(x, y, tag));
        driveStart(x, y);
        checkOutput({tag, ".busy"}, 64'(busy), 64'd1);
    endtask

    // Waits (bounded) for done and compares against the scoreboard head.
    // pulseAt > 0 injects a second start pulse during that cycle.
    task automatic collectResult(input int pulseAt);
        exp_t e;
        int   lat;
        bit   seen;
        e    = sbq.pop_front();
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                lat  = c;
            end else begin
                if (c == pulseAt - 1) begin
                    start = 1'b1;
                    a     = 25'd7;
                    b     = 25'd7;
                end
                if (c == pulseAt) begin
                    start = 1'b0;
                    checkOutput({e.tag, ".busyHeld"}, 64'(busy), 64'd1);
                end
            end
        end
        checkOutput({e.tag, ".done"}, 64'(seen), 64'd1);
        if (seen) begin
            checkOutput({e.tag, ".latency"}, 64'(lat), 64'(e.lat));
            checkOutput({e.tag, ".product"}, 64'(product), 64'(e.prod));
            checkOutput({e.tag, ".ovf"}, 64'(ovf), 64'(e.ovf));
            checkOutput({e.tag, ".busyLow"}, 64'(busy), 64'd0);
            @(posedge clk);
            #1;
            checkOutput({e.tag, ".pulse"}, 64'(done), 64'd0);
            checkOutput({e.tag, ".hold"}, 64'(product), 64'(e.prod));
        end
    endtask

    task automatic countDones(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
    endtask

    initial begin
        int            n;
        logic [31:0]   r1;
        logic [31:0]   r2;
        logic [PW-1:0] held;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.ovf", 64'(ovf), 64'd0);
        checkOutput("reset.product", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(25'd16384, 25'd16384, "one_x_one");
        collectResult(0);

        applyStimulus(-25'sd24576, 25'd32768, "m1p5_x_2");
        collectResult(0);
        applyStimulus(25'd32768, -25'sd24576, "2_x_m1p5");
        collectResult(0);

        applyStimulus(-25'sd16777216, -25'sd16777216, "min_x_min");
        collectResult(0);

        applyStimulus(-25'sd16777216, 25'd1, "min_x_one");
        collectResult(0);

        // Second start mid-operation must be ignored
        applyStimulus(25'd3, 25'd5, "ignore_start");
        collectResult(10);
        countDones(40, n);
        checkOutput("ignore_start.noSecondDone", 64'(n), 64'd0);
        checkOutput("ignore_start.keep", 64'(product), 64'd15);

        // Operand changes without start must not disturb the held result
        held = product;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 25'(i * 977 + 1);
            b = 25'(i * 31 + 2);
        end
        countDones(5, n);
        checkOutput("idle_change.noDone", 64'(n), 64'd0);
        checkOutput("idle_change.hold", 64'(product), 64'(held));

        // Reset mid-operation aborts without a done pulse
        driveStart(25'd100, -25'sd100);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort.busy", 64'(busy), 64'd0);
        checkOutput("abort.product", 64'(product), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        countDones(40, n);
        checkOutput("abort.noDone", 64'(n), 64'd0);
        applyStimulus(25'd100, -25'sd100, "after_abort");
        collectResult(0);

        applyStimulus(25'd0, 25'd12345, "zero_a");
        collectResult(0);
        applyStimulus(-25'sd777, 25'd0, "zero_b");
        collectResult(0);

        for (int i = 0; i < 4; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            applyStimulus(r1[N-1:0], r2[N-1:0], $sformatf("rand%0d", i));
            collectResult(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fixed_mult_seq.md
Name: fixed_mult_seq

Overview:
- Sequential signed fixed-point multiplier, radix-2 Booth, one Booth step per clock.
- Takes two Q(ent.frac) operands, each cant_bits wide with a sign bit.
- Produces the full-precision product, 2*ent+2*frac+1 bits wide (Q(2ent.2frac) plus sign).
- This is the producer side of the wide-product interface: `product` connects directly to the `in` port of the truncation/saturation stage, which reduces it back to cant_bits.

Parameters:
- cant_bits, 25: operand width; must equal 1+ent+frac.
- ent, 10: integer bits per operand, excluding sign.
- frac, 14: fractional bits per operand.
- Derived PW = 2*ent+2*frac+1 (49 at defaults): product width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- a  input  cant_bits  signed multiplicand, Q(ent.frac).
- b  input  cant_bits  signed multiplier, Q(ent.frac).
- busy  output  1  high from the cycle after an accepted start until done is asserted.
- done  output  1  one-cycle pulse; product and ovf are valid from this cycle on.
- ovf  output  1  high when the exact product does not fit in PW bits; held with product.
- product  output  PW  signed product; holds its value until the next accepted start completes.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, ovf=0, product=0; step counter=0; internal accumulator cleared.
- States: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - On start=1, latch a into the multiplicand register (sign-extended to 2*cant_bits) and b into the Booth register with appended q(-1)=0.
  - Clear the accumulator, load counter=cant_bits, go to CALC, set busy=1.
  - start=0: stay in IDLE; outputs hold.
- CALC, one step per cycle, using the pair {b_reg[0], q(-1)}:
  - 01: acc += A.
  - 10: acc -= A.
  - 00 or 11: no add.
  - Then arithmetic-shift {acc, b_reg, q(-1)} right by 1 and decrement the counter.
  - Arithmetic uses a 2*cant_bits signed intermediate; no truncation inside the loop.
  - After cant_bits steps (counter reaches 0), go to DONE.
- DONE:
  - Register the full 2*cant_bits result R.
  - If R equals exactly +2^(2*cant_bits-2), which only occurs for a=b=-2^(cant_bits-1): product = {1'b0, all ones}, ovf=1.
  - Otherwise: product = R[PW-1:0] (the dropped MSB equals the sign), ovf=0.
  - done=1 for exactly this cycle, busy=0 in the same cycle, next state IDLE.
- Latency: start accepted at edge k; done=1 during the cycle after edge k+cant_bits+1, i.e. 26 cycles at default.
- Throughput: a new start may be accepted in the IDLE cycle following DONE (cycle after the done pulse).
- start while busy (CALC or DONE) is ignored; a and b may change freely while busy.
- Operand changes in IDLE without start have no effect.
- Reset asserted mid-operation aborts immediately. No done pulse is produced; product returns to 0.
- Binary point: product LSB weight is 2^-(2*frac); integer field is product[PW-2:2*frac].

Optional Feature:
- Macro: FIXED_MULT_FAST_ZERO_EN.
- Defined: in IDLE, if start=1 and (a==0 or b==0), go directly to DONE with R=0. The done pulse comes one cycle after acceptance, with product=0 and ovf=0. busy stays high for that one intervening cycle.
- Not defined: zero operands take the full cant_bits-step path; result is still 0, latency is unchanged.

Test Plan:
- a=16384, b=16384 (1.0*1.0), start one cycle -> done exactly 26 cycles later, product=268435456 (2^28), ovf=0.
- a=-24576 (-1.5), b=32768 (2.0) -> product=-805306368, ovf=0. Swapping operands gives an identical result.
- a=b=-16777216 (-2^24) -> product=2^48-1 (0x0_FFFF_FFFF_FFFF), ovf=1.
- Accept start with a=3, b=5; pulse start again at cycle 10 with a=7, b=7 -> single done at cycle 26, product=15; the second start is ignored and busy stays high.
- Start with a=100, b=-100; deassert rst_n at cycle 12 for 2 cycles -> no done pulse; busy=0, product=0. Next start completes normally with -10000.
- a=0, b=12345 -> macro defined: done 1 cycle after acceptance, product=0. Undefined: done at 26 cycles, product=0.
